// File: rtl/cix32_pushpop_seq.sv
// PUSHA(D)/POPA(D) microsequencer: walks the eight GPRs through a single-outstanding
// memory channel, then writes the final ESP back through the regfile write port.
module cix32_pushpop_seq #(
    parameter logic [2:0] SP_IDX = 3'd4,
    parameter int         NREGS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_pop,
    input  logic        op_size16,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [2:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  rf_wstrb,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOADSP | read ESP from the regfile and latch it as base
    // XFER   | one memory beat per GPR, advancing on mem_ready
    // UPDSP  | write the final ESP
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADSP = 3'd1,
        XFER   = 3'd2,
        UPDSP  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] LAST = 3'(NREGS - 1);

    state_t      state_q, state_d;
    logic        op_pop_q, op_pop_d;
    logic        size16_q, size16_d;
    logic [2:0]  i_q, i_d;
    logic [31:0] base_q, base_d;

    logic [1:0]  sh;
    logic [3:0]  strb;
    logic [31:0] mask;
    logic [31:0] beat_off;
    logic [31:0] push_off;
    logic [31:0] total_off;
    logic [2:0]  pop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_pop_q <= 1'b0;
            size16_q <= 1'b0;
            i_q      <= 3'd0;
            base_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_pop_q <= op_pop_d;
            size16_q <= size16_d;
            i_q      <= i_d;
            base_q   <= base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_pop_d = op_pop_q;
        size16_d = size16_q;
        i_d      = i_q;
        base_d   = base_q;

        busy      = 1'b0;
        done      = 1'b0;
        rf_raddr  = 3'd0;
        rf_waddr  = 3'd0;
        rf_wdata  = 32'd0;
        rf_wstrb  = 4'd0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_be    = 4'd0;
        mem_wdata = 32'd0;

        // slot size is a shift: 2 bytes -> <<1, 4 bytes -> <<2
        sh        = size16_q ? 2'd1 : 2'd2;
        strb      = size16_q ? 4'b0011 : 4'b1111;
        mask      = size16_q ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        beat_off  = {29'd0, i_q} << sh;
        push_off  = ({29'd0, i_q} + 32'd1) << sh;
        total_off = 32'd8 << sh;
        pop_reg   = LAST - i_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_pop_d = op_pop;
                    size16_d = op_size16;
                    i_d      = 3'd0;
                    state_d  = LOADSP;
                end
            end
            LOADSP: begin
                busy     = 1'b1;
                rf_raddr = SP_IDX;
                base_d   = rf_rdata;
                state_d  = XFER;
            end
            XFER: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_be  = strb;
                if (op_pop_q) begin
                    mem_addr = base_q + beat_off;
                    if (mem_ready) begin
                        // the stacked ESP slot is read but never written back
                        rf_we    = (pop_reg != SP_IDX);
                        rf_waddr = pop_reg;
                        rf_wdata = mem_rdata;
                        rf_wstrb = strb;
                    end
                end else begin
                    rf_raddr  = i_q;
                    mem_we    = 1'b1;
                    mem_addr  = base_q - push_off;
                    mem_wdata = ((i_q == SP_IDX) ? base_q : rf_rdata) & mask;
                end
                if (mem_ready) begin
                    i_d = i_q + 3'd1;
                    if (i_q == LAST) begin
                        state_d = UPDSP;
                    end
                end
            end
            UPDSP: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = SP_IDX;
                rf_wdata = op_pop_q ? (base_q + total_off) : (base_q - total_off);
                rf_wstrb = strb;
                state_d  = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
